// File: rtl/decode.sv
// Instruction decode stage: IF/ID instruction register, 32x32 register file with
// writeback port, and combinational control decode of the held instruction.
// Optional build macro DECODE_WB_BYPASS_EN: when defined, a register read that hits
// the register being written this cycle returns the write data (write-through).
module decode (
    input  logic        clk,
    input  logic        reset,
    input  logic        AnyStall,
    input  logic [31:0] FetchData_IF,
    input  logic        RegWrite_ME,
    input  logic        MemToReg_ME,
    input  logic [31:0] RdDat_ME,
    input  logic [31:0] Result_ME,
    input  logic [4:0]  WriteReg_ME,
    output logic        Jump_ID,
    output logic [25:0] JumpTgt_ID,
    output logic        RegWrite_ID,
    output logic        RegDst_ID,
    output logic        AluSrc_ID,
    output logic        MemWrite_ID,
    output logic        MemToReg_ID,
    output logic        Link_ID,
    output logic [2:0]  BpCtl_ID,
    output logic [3:0]  AluControl_ID,
    output logic [31:0] SignImm_ID,
    output logic [15:0] Imm_ID,
    output logic [4:0]  Rs_ID,
    output logic [4:0]  Rt_ID,
    output logic [4:0]  Rd_ID,
    output logic [31:0] RdDatA_ID,
    output logic [31:0] RdDatB_ID
);

    logic [31:0] instr_q;
    logic [31:0] regs_q [32];
    logic [31:0] wb_data;
    logic        wb_en;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        r_ok;
    logic        zext;

    assign wb_data = MemToReg_ME ? RdDat_ME : Result_ME;
    assign wb_en   = RegWrite_ME && (WriteReg_ME != 5'd0);
    assign opcode  = instr_q[31:26];
    assign funct   = instr_q[5:0];

    // IF/ID instruction register; stall holds the current instruction
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_q <= 32'h0000_0000;
        end else if (!AnyStall) begin
            instr_q <= FetchData_IF;
        end
    end

    // Register file writeback; runs regardless of stall, r0 is never written
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 32'h0000_0000;
            end
        end else if (wb_en) begin
            regs_q[WriteReg_ME] <= wb_data;
        end
    end

    // Register field extraction; jal links into r31
    always_comb begin
        Rs_ID      = instr_q[25:21];
        Rt_ID      = instr_q[20:16];
        Rd_ID      = (opcode == 6'h03) ? 5'd31 : instr_q[15:11];
        Imm_ID     = instr_q[15:0];
        JumpTgt_ID = instr_q[25:0];
        zext       = (opcode == 6'h0C) || (opcode == 6'h0D) || (opcode == 6'h0E);
        SignImm_ID = zext ? {16'h0000, instr_q[15:0]} : {{16{instr_q[15]}}, instr_q[15:0]};
    end

    // Register file read ports
    always_comb begin
        RdDatA_ID = regs_q[Rs_ID];
        RdDatB_ID = regs_q[Rt_ID];
`ifdef DECODE_WB_BYPASS_EN
        if (wb_en && (WriteReg_ME == Rs_ID)) RdDatA_ID = wb_data;
        if (wb_en && (WriteReg_ME == Rt_ID)) RdDatB_ID = wb_data;
`else
`endif
        if (Rs_ID == 5'd0) RdDatA_ID = 32'h0000_0000;
        if (Rt_ID == 5'd0) RdDatB_ID = 32'h0000_0000;
    end

    // Control decode; anything unrecognised (including all-zero) decodes as a NOP
    always_comb begin
        Jump_ID       = 1'b0;
        RegWrite_ID   = 1'b0;
        RegDst_ID     = 1'b0;
        AluSrc_ID     = 1'b0;
        MemWrite_ID   = 1'b0;
        MemToReg_ID   = 1'b0;
        Link_ID       = 1'b0;
        BpCtl_ID      = 3'b000;
        AluControl_ID = 4'b0000;
        r_ok          = 1'b0;
        case (opcode)
            6'h00: begin
                if (instr_q != 32'h0000_0000) begin
                    r_ok = 1'b1;
                    case (funct)
                        6'h20, 6'h21: AluControl_ID = 4'b0010;
                        6'h22, 6'h23: AluControl_ID = 4'b0110;
                        6'h24:        AluControl_ID = 4'b0000;
                        6'h25:        AluControl_ID = 4'b0001;
                        6'h26:        AluControl_ID = 4'b0011;
                        6'h27:        AluControl_ID = 4'b0100;
                        6'h2A:        AluControl_ID = 4'b0111;
                        6'h2B:        AluControl_ID = 4'b1011;
                        6'h00:        AluControl_ID = 4'b0101;
                        6'h02:        AluControl_ID = 4'b1000;
                        6'h03:        AluControl_ID = 4'b1001;
                        default:      r_ok = 1'b0;
                    endcase
                end
                RegWrite_ID = r_ok;
                RegDst_ID   = r_ok;
            end
            6'h08, 6'h09: begin RegWrite_ID = 1'b1; AluSrc_ID = 1'b1; AluControl_ID = 4'b0010; end
            6'h0C:        begin RegWrite_ID = 1'b1; AluSrc_ID = 1'b1; AluControl_ID = 4'b0000; end
            6'h0D:        begin RegWrite_ID = 1'b1; AluSrc_ID = 1'b1; AluControl_ID = 4'b0001; end
            6'h0E:        begin RegWrite_ID = 1'b1; AluSrc_ID = 1'b1; AluControl_ID = 4'b0011; end
            6'h0A:        begin RegWrite_ID = 1'b1; AluSrc_ID = 1'b1; AluControl_ID = 4'b0111; end
            6'h0B:        begin RegWrite_ID = 1'b1; AluSrc_ID = 1'b1; AluControl_ID = 4'b1011; end
            6'h0F:        begin RegWrite_ID = 1'b1; AluSrc_ID = 1'b1; AluControl_ID = 4'b1010; end
            6'h23: begin
                RegWrite_ID   = 1'b1;
                AluSrc_ID     = 1'b1;
                MemToReg_ID   = 1'b1;
                AluControl_ID = 4'b0010;
            end
            6'h2B: begin
                MemWrite_ID   = 1'b1;
                AluSrc_ID     = 1'b1;
                AluControl_ID = 4'b0010;
            end
            6'h04: begin BpCtl_ID = 3'b001; AluControl_ID = 4'b0110; end
            6'h05: begin BpCtl_ID = 3'b010; AluControl_ID = 4'b0110; end
            6'h06: begin BpCtl_ID = 3'b011; AluControl_ID = 4'b0110; end
            6'h07: begin BpCtl_ID = 3'b100; AluControl_ID = 4'b0110; end
            6'h02: Jump_ID = 1'b1;
            6'h03: begin
                Jump_ID     = 1'b1;
                Link_ID     = 1'b1;
                RegWrite_ID = 1'b1;
                RegDst_ID   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_decode.sv
// Self-checking bench for decode: scoreboard of expected decode results pushed when an
// instruction is fetched and popped one cycle later when the decode outputs are valid.
module tb_decode;

    logic        clk = 1'b0;
    logic        reset;
    logic        AnyStall;
    logic [31:0] FetchData_IF;
    logic        RegWrite_ME;
    logic        MemToReg_ME;
    logic [31:0] RdDat_ME;
    logic [31:0] Result_ME;
    logic [4:0]  WriteReg_ME;
    logic        Jump_ID;
    logic [25:0] JumpTgt_ID;
    logic        RegWrite_ID;
    logic        RegDst_ID;
    logic        AluSrc_ID;
    logic        MemWrite_ID;
    logic        MemToReg_ID;
    logic        Link_ID;
    logic [2:0]  BpCtl_ID;
    logic [3:0]  AluControl_ID;
    logic [31:0] SignImm_ID;
    logic [15:0] Imm_ID;
    logic [4:0]  Rs_ID;
    logic [4:0]  Rt_ID;
    logic [4:0]  Rd_ID;
    logic [31:0] RdDatA_ID;
    logic [31:0] RdDatB_ID;

    typedef struct {
        logic [13:0] ctl;
        logic [31:0] simm;
        logic [4:0]  rd;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    decode dut (
        .clk(clk), .reset(reset), .AnyStall(AnyStall), .FetchData_IF(FetchData_IF),
        .RegWrite_ME(RegWrite_ME), .MemToReg_ME(MemToReg_ME), .RdDat_ME(RdDat_ME),
        .Result_ME(Result_ME), .WriteReg_ME(WriteReg_ME), .Jump_ID(Jump_ID),
        .JumpTgt_ID(JumpTgt_ID), .RegWrite_ID(RegWrite_ID), .RegDst_ID(RegDst_ID),
        .AluSrc_ID(AluSrc_ID), .MemWrite_ID(MemWrite_ID), .MemToReg_ID(MemToReg_ID),
        .Link_ID(Link_ID), .BpCtl_ID(BpCtl_ID), .AluControl_ID(AluControl_ID),
        .SignImm_ID(SignImm_ID), .Imm_ID(Imm_ID), .Rs_ID(Rs_ID), .Rt_ID(Rt_ID),
        .Rd_ID(Rd_ID), .RdDatA_ID(RdDatA_ID), .RdDatB_ID(RdDatB_ID)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required $finish before 200000");
        $fatal(1);
    end

    // {jump, regwrite, regdst, alusrc, memwrite, memtoreg, link, bpctl, aluctl}
    function automatic logic [13:0] mk(input logic j, input logic rw, input logic rdst,
                                       input logic as, input logic mw, input logic mtr,
                                       input logic lk, input logic [2:0] bp,
                                       input logic [3:0] alu);
        return {j, rw, rdst, as, mw, mtr, lk, bp, alu};
    endfunction

    function automatic logic [13:0] obs_ctl();
        return {Jump_ID, RegWrite_ID, RegDst_ID, AluSrc_ID, MemWrite_ID, MemToReg_ID,
                Link_ID, BpCtl_ID, AluControl_ID};
    endfunction

    function automatic exp_t mk_exp(input logic [13:0] c, input logic [31:0] s,
                                    input logic [4:0] r);
        exp_t e;
        e.ctl  = c;
        e.simm = s;
        e.rd   = r;
        return e;
    endfunction

    // Empty scoreboard yields X expectations so the following comparison fails
    function automatic exp_t pop_exp();
        exp_t e;
        if (sb.size() == 0) begin
            e.ctl  = 'x;
            e.simm = 'x;
            e.rd   = 'x;
        end else begin
            e = sb.pop_front();
        end
        return e;
    endfunction

    task automatic issue(input logic [31:0] ins, input exp_t e);
        sb.push_back(e);
        AnyStall     = 1'b0;
        FetchData_IF = ins;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        reset        = 1'b1;
        AnyStall     = 1'b0;
        FetchData_IF = 32'h2008_0005;
        RegWrite_ME  = 1'b0;
        MemToReg_ME  = 1'b0;
        RdDat_ME     = '0;
        Result_ME    = '0;
        WriteReg_ME  = '0;
        #12;
        reset = 1'b0;
        #1;
        e = mk_exp(14'h0, 32'h0, 5'd0);
        n_cmp++;
        if (obs_ctl() !== e.ctl) begin
            n_bad++;
            $display("FAIL reset_ctl: got %h required %h", obs_ctl(), e.ctl);
        end
        n_cmp++;
        if (SignImm_ID !== 32'h0 || Rt_ID !== 5'd0) begin
            n_bad++;
            $display("FAIL reset_instr: got simm %h rt %0d required 0/0", SignImm_ID, Rt_ID);
        end
    endtask

    task automatic test_addi();
        exp_t e;
        issue(32'h2008_0005, mk_exp(mk(0, 1, 0, 1, 0, 0, 0, 3'b000, 4'b0010), 32'h5, 5'd0));
        e = pop_exp();
        n_cmp++;
        if (obs_ctl() !== e.ctl || SignImm_ID !== e.simm || Rt_ID !== 5'd8) begin
            n_bad++;
            $display("FAIL addi: got ctl %h simm %h rt %0d required ctl %h simm %h rt 8",
                     obs_ctl(), SignImm_ID, Rt_ID, e.ctl, e.simm);
        end
    endtask

    task automatic test_imm_ext();
        logic [31:0] ins [2] = '{32'h3C01_FFFF, 32'h3421_FFFF};
        exp_t        e;
        sb.push_back(mk_exp(mk(0, 1, 0, 1, 0, 0, 0, 3'b000, 4'b1010), 32'hFFFF_FFFF, 5'd31));
        sb.push_back(mk_exp(mk(0, 1, 0, 1, 0, 0, 0, 3'b000, 4'b0001), 32'h0000_FFFF, 5'd31));
        for (int i = 0; i < 2; i++) begin
            FetchData_IF = ins[i];
            @(posedge clk);
            #1;
            e = pop_exp();
            n_cmp++;
            if (obs_ctl() !== e.ctl || SignImm_ID !== e.simm || Imm_ID !== 16'hFFFF) begin
                n_bad++;
                $display("FAIL imm_ext[%0d]: got ctl %h simm %h required ctl %h simm %h",
                         i, obs_ctl(), SignImm_ID, e.ctl, e.simm);
            end
        end
    endtask

    task automatic test_jump_branch();
        exp_t e;
        issue(32'h0C00_0010, mk_exp(mk(1, 1, 1, 0, 0, 0, 1, 3'b000, 4'b0000), 32'h10, 5'd31));
        e = pop_exp();
        n_cmp++;
        if (obs_ctl() !== e.ctl || Rd_ID !== e.rd || JumpTgt_ID !== 26'h0000010) begin
            n_bad++;
            $display("FAIL jal: got ctl %h rd %0d tgt %h required ctl %h rd 31 tgt 0000010",
                     obs_ctl(), Rd_ID, JumpTgt_ID, e.ctl);
        end
        issue(32'h1022_0003, mk_exp(mk(0, 0, 0, 0, 0, 0, 0, 3'b001, 4'b0110), 32'h3, 5'd0));
        e = pop_exp();
        n_cmp++;
        if (obs_ctl() !== e.ctl || RegWrite_ID !== 1'b0) begin
            n_bad++;
            $display("FAIL beq: got ctl %h required %h", obs_ctl(), e.ctl);
        end
    endtask

    // One new instruction every cycle; compare each result as it emerges
    task automatic test_back_to_back();
        logic [31:0] ins [17];
        exp_t        e;
        ins = '{32'h0800_0004, 32'h8C43_0008, 32'hAC43_FFF8, 32'h3042_F000, 32'h2842_FFFF,
                32'h1443_FFFE, 32'h1840_0002, 32'h1C40_0002, 32'h0109_5022, 32'h0009_4043,
                32'h0109_5027, 32'h0109_502B, 32'h0009_4042, 32'h0100_0008, 32'hFC00_0000,
                32'h0000_0000, 32'h3842_00F0};
        sb.push_back(mk_exp(mk(1, 0, 0, 0, 0, 0, 0, 3'b000, 4'b0000), 32'h4, 5'd0));
        sb.push_back(mk_exp(mk(0, 1, 0, 1, 0, 1, 0, 3'b000, 4'b0010), 32'h8, 5'd0));
        sb.push_back(mk_exp(mk(0, 0, 0, 1, 1, 0, 0, 3'b000, 4'b0010), 32'hFFFF_FFF8, 5'd31));
        sb.push_back(mk_exp(mk(0, 1, 0, 1, 0, 0, 0, 3'b000, 4'b0000), 32'h0000_F000, 5'd30));
        sb.push_back(mk_exp(mk(0, 1, 0, 1, 0, 0, 0, 3'b000, 4'b0111), 32'hFFFF_FFFF, 5'd31));
        sb.push_back(mk_exp(mk(0, 0, 0, 0, 0, 0, 0, 3'b010, 4'b0110), 32'hFFFF_FFFE, 5'd31));
        sb.push_back(mk_exp(mk(0, 0, 0, 0, 0, 0, 0, 3'b011, 4'b0110), 32'h2, 5'd0));
        sb.push_back(mk_exp(mk(0, 0, 0, 0, 0, 0, 0, 3'b100, 4'b0110), 32'h2, 5'd0));
        sb.push_back(mk_exp(mk(0, 1, 1, 0, 0, 0, 0, 3'b000, 4'b0110), 32'h5022, 5'd10));
        sb.push_back(mk_exp(mk(0, 1, 1, 0, 0, 0, 0, 3'b000, 4'b1001), 32'h4043, 5'd8));
        sb.push_back(mk_exp(mk(0, 1, 1, 0, 0, 0, 0, 3'b000, 4'b0100), 32'h5027, 5'd10));
        sb.push_back(mk_exp(mk(0, 1, 1, 0, 0, 0, 0, 3'b000, 4'b1011), 32'h502B, 5'd10));
        sb.push_back(mk_exp(mk(0, 1, 1, 0, 0, 0, 0, 3'b000, 4'b1000), 32'h4042, 5'd8));
        sb.push_back(mk_exp(14'h0, 32'h8, 5'd0));
        sb.push_back(mk_exp(14'h0, 32'h0, 5'd0));
        sb.push_back(mk_exp(14'h0, 32'h0, 5'd0));
        // xori: zero-extended immediate
        sb.push_back(mk_exp(mk(0, 1, 0, 1, 0, 0, 0, 3'b000, 4'b0011), 32'h0000_00F0, 5'd0));
        for (int i = 0; i < 17; i++) begin
            FetchData_IF = ins[i];
            @(posedge clk);
            #1;
            e = pop_exp();
            n_cmp++;
            if (obs_ctl() !== e.ctl || SignImm_ID !== e.simm || Rd_ID !== e.rd) begin
                n_bad++;
                $display("FAIL b2b[%0d] %h: got ctl %h simm %h rd %0d required ctl %h simm %h rd %0d",
                         i, ins[i], obs_ctl(), SignImm_ID, Rd_ID, e.ctl, e.simm, e.rd);
            end
        end
    endtask

    task automatic test_writeback();
        exp_t e;
        RegWrite_ME = 1'b1;
        MemToReg_ME = 1'b0;
        WriteReg_ME = 5'd8;
        Result_ME   = 32'h0000_1234;
        RdDat_ME    = 32'hDEAD_BEEF;
        issue(32'h0108_4820, mk_exp(mk(0, 1, 1, 0, 0, 0, 0, 3'b000, 4'b0010), 32'h4820, 5'd9));
        RegWrite_ME = 1'b0;
        #1;
        e = pop_exp();
        n_cmp++;
        if (obs_ctl() !== e.ctl || RdDatA_ID !== 32'h1234 || RdDatB_ID !== 32'h1234) begin
            n_bad++;
            $display("FAIL wb_result: got ctl %h A %h B %h required ctl %h A/B 00001234",
                     obs_ctl(), RdDatA_ID, RdDatB_ID, e.ctl);
        end
        // Load path: write data selected from RdDat_ME
        RegWrite_ME = 1'b1;
        MemToReg_ME = 1'b1;
        WriteReg_ME = 5'd10;
        RdDat_ME    = 32'hCAFE_F00D;
        Result_ME   = 32'h1111_1111;
        @(posedge clk);
        #1;
        RegWrite_ME = 1'b0;
        MemToReg_ME = 1'b0;
        issue(32'h0140_5825, mk_exp(mk(0, 1, 1, 0, 0, 0, 0, 3'b000, 4'b0001), 32'h5825, 5'd11));
        e = pop_exp();
        n_cmp++;
        if (obs_ctl() !== e.ctl || RdDatA_ID !== 32'hCAFE_F00D || RdDatB_ID !== 32'h0) begin
            n_bad++;
            $display("FAIL wb_load: got ctl %h A %h B %h required ctl %h A cafef00d B 0",
                     obs_ctl(), RdDatA_ID, RdDatB_ID, e.ctl);
        end
    endtask

    task automatic test_bypass();
        logic [31:0] exp_same;
        exp_t        e;
        issue(32'h0108_4820, mk_exp(mk(0, 1, 1, 0, 0, 0, 0, 3'b000, 4'b0010), 32'h4820, 5'd9));
        e = pop_exp();
        n_cmp++;
        if (obs_ctl() !== e.ctl || RdDatA_ID !== 32'h1234) begin
            n_bad++;
            $display("FAIL bypass_pre: got ctl %h A %h required ctl %h A 00001234",
                     obs_ctl(), RdDatA_ID, e.ctl);
        end
`ifdef DECODE_WB_BYPASS_EN
        exp_same = 32'h0000_5555;
`else
        exp_same = 32'h0000_1234;
`endif
        RegWrite_ME = 1'b1;
        MemToReg_ME = 1'b0;
        WriteReg_ME = 5'd8;
        Result_ME   = 32'h0000_5555;
        #1;
        n_cmp++;
        if (RdDatA_ID !== exp_same || RdDatB_ID !== exp_same) begin
            n_bad++;
            $display("FAIL bypass_same_cycle: got A %h B %h required %h",
                     RdDatA_ID, RdDatB_ID, exp_same);
        end
        @(posedge clk);
        #1;
        RegWrite_ME = 1'b0;
        #1;
        n_cmp++;
        if (RdDatA_ID !== 32'h5555 || RdDatB_ID !== 32'h5555) begin
            n_bad++;
            $display("FAIL bypass_after_edge: got A %h B %h required 00005555",
                     RdDatA_ID, RdDatB_ID);
        end
    endtask

    task automatic test_r0();
        exp_t e;
        issue(32'h0000_4820, mk_exp(mk(0, 1, 1, 0, 0, 0, 0, 3'b000, 4'b0010), 32'h4820, 5'd9));
        e = pop_exp();
        RegWrite_ME = 1'b1;
        MemToReg_ME = 1'b0;
        WriteReg_ME = 5'd0;
        Result_ME   = 32'hFFFF_FFFF;
        #1;
        n_cmp++;
        if (obs_ctl() !== e.ctl || RdDatA_ID !== 32'h0 || RdDatB_ID !== 32'h0) begin
            n_bad++;
            $display("FAIL r0_same_cycle: got ctl %h A %h B %h required ctl %h A/B 0",
                     obs_ctl(), RdDatA_ID, RdDatB_ID, e.ctl);
        end
        @(posedge clk);
        #1;
        RegWrite_ME = 1'b0;
        #1;
        n_cmp++;
        if (RdDatA_ID !== 32'h0 || RdDatB_ID !== 32'h0) begin
            n_bad++;
            $display("FAIL r0_after_write: got A %h B %h required 0", RdDatA_ID, RdDatB_ID);
        end
    endtask

    task automatic test_stall();
        logic [31:0] junk [2] = '{32'hFFFF_FFFF, 32'h0C00_0010};
        logic [13:0] addi_ctl;
        exp_t        e;
        addi_ctl = mk(0, 1, 0, 1, 0, 0, 0, 3'b000, 4'b0010);
        issue(32'h2008_0005, mk_exp(addi_ctl, 32'h5, 5'd0));
        e = pop_exp();
        n_cmp++;
        if (obs_ctl() !== e.ctl) begin
            n_bad++;
            $display("FAIL stall_setup: got ctl %h required %h", obs_ctl(), e.ctl);
        end
        AnyStall    = 1'b1;
        RegWrite_ME = 1'b1;
        MemToReg_ME = 1'b0;
        WriteReg_ME = 5'd12;
        Result_ME   = 32'h0000_0077;
        for (int i = 0; i < 2; i++) begin
            FetchData_IF = junk[i];
            @(posedge clk);
            #1;
            RegWrite_ME = 1'b0;
            n_cmp++;
            if (obs_ctl() !== addi_ctl || Rt_ID !== 5'd8 || SignImm_ID !== 32'h5) begin
                n_bad++;
                $display("FAIL stall_hold[%0d]: got ctl %h rt %0d simm %h required ctl %h rt 8 simm 5",
                         i, obs_ctl(), Rt_ID, SignImm_ID, addi_ctl);
            end
        end
        issue(32'h0180_4820, mk_exp(mk(0, 1, 1, 0, 0, 0, 0, 3'b000, 4'b0010), 32'h4820, 5'd9));
        e = pop_exp();
        n_cmp++;
        if (obs_ctl() !== e.ctl || RdDatA_ID !== 32'h77) begin
            n_bad++;
            $display("FAIL stall_writeback: got ctl %h A %h required ctl %h A 00000077",
                     obs_ctl(), RdDatA_ID, e.ctl);
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        issue(32'h0140_5825, mk_exp(mk(0, 1, 1, 0, 0, 0, 0, 3'b000, 4'b0001), 32'h5825, 5'd11));
        e = pop_exp();
        n_cmp++;
        if (obs_ctl() !== e.ctl || RdDatA_ID !== 32'hCAFE_F00D) begin
            n_bad++;
            $display("FAIL areset_setup: got ctl %h A %h required ctl %h A cafef00d",
                     obs_ctl(), RdDatA_ID, e.ctl);
        end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (obs_ctl() !== 14'h0 || SignImm_ID !== 32'h0) begin
            n_bad++;
            $display("FAIL areset_immediate: got ctl %h simm %h required 0/0",
                     obs_ctl(), SignImm_ID);
        end
        #3;
        reset = 1'b0;
        issue(32'h0140_5825, mk_exp(mk(0, 1, 1, 0, 0, 0, 0, 3'b000, 4'b0001), 32'h5825, 5'd11));
        e = pop_exp();
        n_cmp++;
        if (obs_ctl() !== e.ctl || RdDatA_ID !== 32'h0) begin
            n_bad++;
            $display("FAIL areset_regfile: got ctl %h A %h required ctl %h A 0",
                     obs_ctl(), RdDatA_ID, e.ctl);
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_imm_ext();
        test_jump_branch();
        test_back_to_back();
        test_writeback();
        test_bypass();
        test_r0();
        test_stall();
        test_async_reset();
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d entries left required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
